// File: rtl/mips_muldiv_unit_if.sv
// Pipeline-facing request/result bundle of the MIPS multiply/divide unit.
// The master is the pipeline and the slave is the HI/LO owner.
interface mips_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic                  mthi;
  logic                  mtlo;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  busy;
  logic                  done;

  modport master (
    output start, op, op1, op2, mthi, mtlo, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, op1, op2, mthi, mtlo, wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: the magnitudes are processed over DATA_WIDTH steps,
// the sign is fixed in one extra step, and the result is then written to HI/LO.
module mips_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               reset_n,
  mips_muldiv_unit_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;          // multiplicand, or dividend shifting out / quotient shifting in
  logic [W-1:0]     b_q, b_d;          // multiplier (shifts right) or divisor
  logic [2*W-1:0]   acc_q, acc_d;      // product, or remainder in the low half
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_qp_q, neg_qp_d;
  logic             neg_r_q, neg_r_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             done_q, done_d;

  logic             in_signed, op1_neg, op2_neg;
  logic [W-1:0]     mag1, mag2;
  logic [W:0]       mul_sum, div_shift, div_diff;
  logic             div_ok;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quot_fix, rem_fix;

  assign in_signed = ~bus.op[0];
  assign op1_neg   = in_signed & bus.op1[W-1];
  assign op2_neg   = in_signed & bus.op2[W-1];
  assign mag1      = op1_neg ? -bus.op1 : bus.op1;
  assign mag2      = op2_neg ? -bus.op2 : bus.op2;

  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (b_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  assign div_shift = {acc_q[W-1:0], a_q[W-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ok    = ~div_diff[W];

  // The sign flags are latched only for signed ops, so they alone decide the negation.
  assign prod_fix  = neg_qp_q ? -acc_q : acc_q;
  assign quot_fix  = neg_qp_q ? -a_q : a_q;
  assign rem_fix   = neg_r_q ? -acc_q[W-1:0] : acc_q[W-1:0];

  always_comb begin
    // NOTE: every next-state value is defaulted to hold first, so no branch can infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_qp_d = neg_qp_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          a_d      = mag1;
          b_d      = mag2;
          neg_qp_d = op1_neg ^ op2_neg;
          neg_r_d  = op1_neg;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      S_CALC: begin
        if (op_q[1]) begin
          acc_d = {{W{1'b0}}, (div_ok ? div_diff[W-1:0] : div_shift[W-1:0])};
          a_d   = {a_q[W-2:0], div_ok};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
          b_d   = b_q >> 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_qp_q <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_qp_q <= neg_qp_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed vector table, randomized ops against an
// arithmetic model, and hand sequences for ignored requests, MTHI/MTLO and asynchronous reset.
module tb_mips_muldiv_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mips_muldiv_unit_if #(.DATA_WIDTH(32)) bus ();
  mips_muldiv_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference built from plain integer arithmetic; returns {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic [31:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    p  = '0;
    q  = '0;
    r  = '0;
    case (o)
      2'd0: p = sa * sb;
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) begin
          q = a[31] ? 32'd1 : 32'hFFFF_FFFF;   // negated all-ones magnitude when dividend negative
          r = a;
        end else begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
        end
        p = {r, q};
      end
      default: begin
        if (b == 32'd0) begin
          q = 32'hFFFF_FFFF;
          r = a;
        end else begin
          q = a / b;
          r = a % b;
        end
        p = {r, q};
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge right after the completing edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int busy_cyc, output logic done_seen);
    bus.start = 1'b1;
    bus.op    = o;
    bus.op1   = a;
    bus.op2   = b;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cyc  = 0;
    while (bus.busy && busy_cyc < 100) begin
      busy_cyc++;
      @(negedge clk);
    end
    done_seen = bus.done;
  endtask

  initial begin
    int          bc;
    logic        ds;
    int          cyc;
    int          done_cnt;
    logic [1:0]  o;
    logic [31:0] a, b;

    vecs[0] = '{"mult_neg1x2",   2'd0, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{"multu_maxx2",   2'd1, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{"div_m7_2",      2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_7_0",      2'd3, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4] = '{"div_overflow",  2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{"div_7_m2",      2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{"div_m7_0",      2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'h0000_0001};

    bus.start = 1'b0;
    bus.op    = '0;
    bus.op1   = '0;
    bus.op2   = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_hi",   64'(bus.hi), 64'd0);
    check("reset_lo",   64'(bus.lo), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Each op starts on the cycle done is high, exercising back-to-back acceptance.
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, bc, ds);
      check({vecs[i].name, "_busy_cycles"}, 64'(bc), 64'd33);
      check({vecs[i].name, "_done"}, 64'(ds), 64'd1);
      check({vecs[i].name, "_hi"}, 64'(bus.hi), 64'(vecs[i].exp_hi));
      check({vecs[i].name, "_lo"}, 64'(bus.lo), 64'(vecs[i].exp_lo));
    end
    @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("idle_after_done", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      do_op(o, a, b, bc, ds);
      check($sformatf("rand%0d_op%0d_%h_%h_busy", i, o, a, b), 64'(bc), 64'd33);
      check($sformatf("rand%0d_op%0d_%h_%h_hilo", i, o, a, b), {bus.hi, bus.lo}, model(o, a, b));
    end
    @(negedge clk);

    // DIVU 100/7 with a start at busy cycle 5 and an MTHI at busy cycle 10, both to be ignored.
    bus.start = 1'b1;
    bus.op    = 2'd3;
    bus.op1   = 32'd100;
    bus.op2   = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 100) begin
      if (cyc == 5) begin
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.op1   = 32'd3;
        bus.op2   = 32'd3;
      end
      if (cyc == 6) bus.start = 1'b0;
      if (cyc == 10) begin
        bus.mthi  = 1'b1;
        bus.wdata = 32'h0000_DEAD;
      end
      if (cyc == 11) bus.mthi = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("ignored_done_cycle", 64'(cyc), 64'd34);
    check("ignored_hi", 64'(bus.hi), 64'd2);
    check("ignored_lo", 64'(bus.lo), 64'd14);
    @(negedge clk);
    check("ignored_no_restart", 64'(bus.busy), 64'd0);

    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    check("mthi_mtlo_hi", 64'(bus.hi), 64'h1234);
    check("mthi_mtlo_lo", 64'(bus.lo), 64'h1234);

    // Start and MTLO in the same idle cycle: the start wins.
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.op1   = 32'd3;
    bus.op2   = 32'd3;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0000_0055;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mtlo  = 1'b0;
    check("start_mtlo_lo_unchanged", 64'(bus.lo), 64'h1234);
    check("start_mtlo_busy", 64'(bus.busy), 64'd1);
    cyc = 1;
    while (!bus.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("start_mtlo_hi", 64'(bus.hi), 64'd0);
    check("start_mtlo_lo", 64'(bus.lo), 64'd9);
    @(negedge clk);

    // Asynchronous reset in the middle of a MULT.
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.op1   = 32'h1234_5678;
    bus.op2   = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_hi",   64'(bus.hi), 64'd0);
    check("async_reset_lo",   64'(bus.lo), 64'd0);
    check("async_reset_busy", 64'(bus.busy), 64'd0);
    check("async_reset_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("no_done_after_reset", 64'(done_cnt), 64'd0);
    check("idle_after_reset", 64'(bus.busy), 64'd0);

    do_op(2'd0, 32'd6, 32'hFFFF_FFFD, bc, ds);
    check("post_reset_busy_cycles", 64'(bc), 64'd33);
    check("post_reset_hilo", {bus.hi, bus.lo}, model(2'd0, 32'd6, 32'hFFFF_FFFD));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
